memory_access_stage: RTL and testbench

- Memory (MEM) stage of the 16-bit pipelined core; sits directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs and runs loads/stores against data memory through a variable-latency req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding, aborts accesses that exceed a timeout, and registers the MEM/WB pipeline values.

---
 rtl/memory_access_stage.sv | 122 ++++++++++++
 tb/tb_memory_access_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM stage: data-memory req/ack access, timeout abort, MEM/WB register
module memory_access_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wre_memory,
  input  logic              select_writeback_data_mux_memory,
  input  logic              write_memory_enable_memory,
  input  logic [DATA_W-1:0] ALUresult_memory,
  input  logic [DATA_W-1:0] srcB_memory,
  input  logic [15:0]       rd_memory,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_memory,
  output logic              wre_writeback,
  output logic [DATA_W-1:0] writeback_data,
  output logic [15:0]       rd_writeback,
  output logic              bus_error
);

  // Counter holds the number of cycles already spent waiting; it is 0 in IDLE.
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  logic store;
  logic load;
  logic access;
  logic ack_seen;
  logic abort_now;

  // Store wins when both load and store are flagged.
  assign store  = write_memory_enable_memory;
  assign load   = select_writeback_data_mux_memory & ~store;
  assign access = load | store;

  // Request is raised in the same cycle the access arrives; reset kills it at once.
  assign mem_req   = ~reset & (access | (state == WAIT));
  assign mem_we    = mem_req & store;
  assign mem_addr  = ALUresult_memory;
  assign mem_wdata = srcB_memory;

  // An ack only counts while a request is actually outstanding.
  assign ack_seen     = mem_req & mem_ack;
  assign abort_now    = mem_req & ~mem_ack & (wait_cnt == LAST_CNT);
  assign stall_memory = mem_req & ~mem_ack & ~abort_now;

  // Access FSM: tracks outstanding request, wait count and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (abort_now) begin
            bus_error <= 1'b1;
          end else if (stall_memory) begin
            state    <= WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (ack_seen) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (abort_now) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise retire the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      wre_writeback  <= 1'b0;
      writeback_data <= '0;
      rd_writeback   <= '0;
    end else if (stall_memory) begin
      wre_writeback <= 1'b0;
    end else if (!access) begin
      wre_writeback  <= wre_memory;
      writeback_data <= ALUresult_memory;
      rd_writeback   <= rd_memory;
    end else if (abort_now) begin
      wre_writeback <= 1'b0;
      rd_writeback  <= rd_memory;
    end else if (ack_seen && store) begin
      wre_writeback <= 1'b0;
      rd_writeback  <= rd_memory;
    end else if (ack_seen) begin
      wre_writeback  <= wre_memory;
      writeback_data <= mem_rdata;
      rd_writeback   <= rd_memory;
    end else begin
      wre_writeback <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - scoreboard bench for memory_access_stage
module tb_memory_access_stage;

  logic        clk;
  logic        reset;
  logic        wre_memory;
  logic        select_writeback_data_mux_memory;
  logic        write_memory_enable_memory;
  logic [15:0] ALUresult_memory;
  logic [15:0] srcB_memory;
  logic [15:0] rd_memory;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall_memory;
  logic        wre_writeback;
  logic [15:0] writeback_data;
  logic [15:0] rd_writeback;
  logic        bus_error;

  memory_access_stage #(.DATA_W(16), .TIMEOUT(8)) dut (
    .clk                              (clk),
    .reset                            (reset),
    .wre_memory                       (wre_memory),
    .select_writeback_data_mux_memory (select_writeback_data_mux_memory),
    .write_memory_enable_memory       (write_memory_enable_memory),
    .ALUresult_memory                 (ALUresult_memory),
    .srcB_memory                      (srcB_memory),
    .rd_memory                        (rd_memory),
    .mem_req                          (mem_req),
    .mem_we                           (mem_we),
    .mem_addr                         (mem_addr),
    .mem_wdata                        (mem_wdata),
    .mem_rdata                        (mem_rdata),
    .mem_ack                          (mem_ack),
    .stall_memory                     (stall_memory),
    .wre_writeback                    (wre_writeback),
    .writeback_data                   (writeback_data),
    .rd_writeback                     (rd_writeback),
    .bus_error                        (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        req;
    logic        we;
    logic        stall;
    logic        wre;
    logic        berr;
    logic [15:0] data;
    logic [15:0] rd;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Registered outputs expected at the current sampling point.
  logic        cur_wre  = 1'b0;
  logic [15:0] cur_data = 16'h0;
  logic [15:0] cur_rd   = 16'h0;
  logic        cur_berr = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every sampled cycle the DUT presents is compared to the next expected record.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".mem_req"},        {15'h0, mem_req},       {15'h0, e.req});
      chk({e.nm, ".mem_we"},         {15'h0, mem_we},        {15'h0, e.we});
      chk({e.nm, ".stall"},          {15'h0, stall_memory},  {15'h0, e.stall});
      chk({e.nm, ".wre_wb"},         {15'h0, wre_writeback}, {15'h0, e.wre});
      chk({e.nm, ".wb_data"},        writeback_data,         e.data);
      chk({e.nm, ".rd_wb"},          rd_writeback,           e.rd);
      chk({e.nm, ".bus_error"},      {15'h0, bus_error},     {15'h0, e.berr});
      if (e.req) begin
        chk({e.nm, ".mem_addr"},  mem_addr,  e.addr);
        chk({e.nm, ".mem_wdata"}, mem_wdata, e.wdata);
      end
    end
  end

  // One cycle of stimulus: drive inputs, queue the expectation, advance a clock.
  task automatic step(input string nm, input logic rst,
                      input logic wre, input logic sel, input logic wme,
                      input logic [15:0] alu, input logic [15:0] srcb, input logic [15:0] rd,
                      input logic ack, input logic [15:0] rdata,
                      input logic e_req, input logic e_we, input logic e_stall,
                      input logic n_wre, input logic [15:0] n_data, input logic [15:0] n_rd,
                      input logic n_berr);
    exp_t e;
    reset                            = rst;
    wre_memory                       = wre;
    select_writeback_data_mux_memory = sel;
    write_memory_enable_memory       = wme;
    ALUresult_memory                 = alu;
    srcB_memory                      = srcb;
    rd_memory                        = rd;
    mem_ack                          = ack;
    mem_rdata                        = rdata;
    e.nm = nm; e.req = e_req; e.we = e_we; e.stall = e_stall;
    e.wre = cur_wre; e.data = cur_data; e.rd = cur_rd; e.berr = cur_berr;
    e.addr = alu; e.wdata = srcb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cur_wre  = n_wre;
    cur_data = n_data;
    cur_rd   = n_rd;
    cur_berr = n_berr;
  endtask

  initial begin
    reset = 1'b1;
    wre_memory = 1'b0;
    select_writeback_data_mux_memory = 1'b0;
    write_memory_enable_memory = 1'b0;
    ALUresult_memory = 16'h0;
    srcB_memory = 16'h0;
    rd_memory = 16'h0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    @(posedge clk);
    #1;

    // Reset with a pending load on the inputs: no request, no stall.
    step("rst",   1, 1,1,0, 16'h0040, 16'h0000, 16'd7, 0, 16'h0000, 0,0,0, 0,16'h0000,16'd0,0);
    // ALU op retires after one cycle.
    step("alu",   0, 1,0,0, 16'h1234, 16'h0000, 16'd5, 0, 16'h0000, 0,0,0, 1,16'h1234,16'd5,0);
    // Load acked on its third request cycle.
    step("ld0",   0, 1,1,0, 16'h0040, 16'h0000, 16'd7, 0, 16'h0000, 1,0,1, 0,16'h1234,16'd5,0);
    step("ld1",   0, 1,1,0, 16'h0040, 16'h0000, 16'd7, 0, 16'h0000, 1,0,1, 0,16'h1234,16'd5,0);
    step("ld2",   0, 1,1,0, 16'h0040, 16'h0000, 16'd7, 1, 16'hBEEF, 1,0,0, 1,16'hBEEF,16'd7,0);
    // Zero-wait store: no stall, no writeback even with wre set.
    step("st",    0, 1,0,1, 16'h0010, 16'h00AA, 16'd9, 1, 16'h0000, 1,1,0, 0,16'hBEEF,16'd9,0);
    // Ack with no request is ignored; ALU result wins.
    step("alu_k", 0, 1,0,0, 16'h5555, 16'h0000, 16'd3, 1, 16'hDEAD, 0,0,0, 1,16'h5555,16'd3,0);
    // Load and store both set behaves as a store.
    step("both",  0, 1,1,1, 16'h0020, 16'h0077, 16'd4, 1, 16'hDEAD, 1,1,0, 0,16'h5555,16'd4,0);
    // Load with no ack aborts on the eighth request cycle.
    for (int k = 0; k < 8; k++) begin
      step("tmo", 0, 1,1,0, 16'h0080, 16'h0000, 16'd6, 0, 16'h0000,
           1, 0, (k < 7), 0, 16'h5555, (k < 7) ? 16'd4 : 16'd6, (k == 7));
    end
    // Next instruction accepted; bus_error sticky.
    step("alu_t", 0, 1,0,0, 16'h0BAD, 16'h0000, 16'd2, 0, 16'h0000, 0,0,0, 1,16'h0BAD,16'd2,1);
    // Load enters WAIT, reset arrives in WAIT cycle 2 together with an ack.
    step("rw0",   0, 1,1,0, 16'h0100, 16'h0000, 16'd8, 0, 16'h0000, 1,0,1, 0,16'h0BAD,16'd2,1);
    step("rw1",   0, 1,1,0, 16'h0100, 16'h0000, 16'd8, 0, 16'h0000, 1,0,1, 0,16'h0BAD,16'd2,1);
    step("rw2",   1, 1,1,0, 16'h0100, 16'h0000, 16'd8, 1, 16'hCAFE, 0,0,0, 0,16'h0000,16'd0,0);
    // ALU op after reset retires normally.
    step("alu_r", 0, 1,0,0, 16'h4321, 16'h0000, 16'd1, 0, 16'h0000, 0,0,0, 1,16'h4321,16'd1,0);
    step("idle",  0, 0,0,0, 16'h0000, 16'h0000, 16'd0, 0, 16'h0000, 0,0,0, 0,16'h0000,16'd0,0);
    step("flush", 0, 0,0,0, 16'h0000, 16'h0000, 16'd0, 0, 16'h0000, 0,0,0, 0,16'h0000,16'd0,0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
